pattern_hist_engine: RTL
========================

# pattern_hist_engine

Hardware pattern seek/match histogram engine, the parametrised successor to the software match-histogram program. On a start pulse it scans a block of data memory and counts, for each word, how many sliding PW-bit windows equal a programmed pattern. It builds a histogram of per-word match counts and writes that histogram back to data memory. It sits beside the CPU as a memory-port master and replaces the hand-coded scan loop.

## Interface
- `DW`, 8: data word width.
- `PW`, 4: pattern width; 1 ≤ PW ≤ DW.
- `AW`, 8: memory address width.
- `CW`, 8: bin counter width; must satisfy CW ≤ DW.
- `NB`: derived localparam, DW-PW+1. Number of bins; bin k holds words with exactly k matches, k = 1..NB.
- `CLK`, in, 1: single system clock. All logic is on the rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request. Sampled only in IDLE.
- `pattern`, in, PW: pattern to match. Latched at start.
- `src_base`, in, AW: first word address. Latched at start.
- `src_len`, in, AW+1: number of words to scan, 0..2^AW. Latched at start.
- `dst_base`, in, AW: address of bin 1. Latched at start.
- `mem_addr`, out, AW: memory address. Resets to 0.
- `mem_re`, out, 1: read strobe. Read data is valid exactly 1 cycle later. Resets to 0.
- `mem_rdata`, in, DW: read data.
- `mem_we`, out, 1: write strobe. Resets to 0.
- `mem_wdata`, out, DW: bin value, zero-extended from CW. Resets to 0.
- `busy`, out, 1: high from the cycle after an accepted start until done. Resets to 0.
- `done`, out, 1: one-cycle pulse at the end of a job. Resets to 0.
- `total`, out, AW+4: total matches across all windows of the last job, saturating at all-ones. Held until the next start. Resets to 0.

## Operation
- FSM states:
  - IDLE, then SCAN on start.
  - SCAN, then DRAIN after the last read is issued.
  - DRAIN, then WRITE.
  - WRITE, then FIN after NB writes.
  - FIN, then IDLE.
- Accepting start latches the inputs and clears all bins and `total`.
- src_len = 0: IDLE goes directly to WRITE. All NB bins are written as 0.
- SCAN: issue one read per cycle at src_base+i mod 2^AW, for i = 0..len-1. Addresses wrap past 2^AW-1 to 0.
- Accumulate stage, one cycle behind the reads:
  - m = number of j in 0..DW-PW with mem_rdata[j+PW-1:j] == pattern.
  - If m ≥ 1, bin[m] increments, saturating at 2^CW-1.
  - `total` adds m, saturating.
  - m = 0 changes no bin.
- WRITE: write bin k to dst_base+k-1 mod 2^AW, for k = 1..NB, one per cycle in ascending order.
- FIN: assert `done` for one cycle and drop `busy` in the same cycle.
- start while busy is ignored, with no queueing.
- Reset asserted mid-job returns to IDLE immediately:
  - all outputs take their reset values;
  - no further reads or writes occur;
  - bins are cleared.
- The destination range must not overlap the source range. Behaviour on overlap is undefined.

## Timing
- Start sampled at edge 0. The first `mem_re` is high in cycle 1.
- With len = L ≥ 1:
  - reads occupy cycles 1..L;
  - DRAIN is cycle L+1 and accumulates the last word;
  - writes occupy cycles L+2..L+NB+1;
  - `done` is high in cycle L+NB+2.
- With L = 0: writes occupy cycles 1..NB, and `done` is high in cycle NB+1.
- Throughput is 1 word per cycle, with no bubbles.
- `mem_re` and `mem_we` are never high in the same cycle.

## Structure
- Package `pattern_hist_pkg`:
  - state enum `hist_state_t` (IDLE, SCAN, DRAIN, WRITE, FIN);
  - default-parameter constants;
  - saturating-add function.
- Sub-module `pattern_window_match`: combinational, parametrised by DW and PW, with inputs word and pattern and output a count of $clog2(NB+1) bits.
- Top level holds the FSM, address counter, read-valid pipeline flag, bin register array `bin[1:NB]`, and the `total` accumulator.

## Test plan
1. Defaults, pattern 0010, src 32, len 1, word 0x24, dst 10 → mem[10..14] = 0,1,0,0,0; total = 2; done in cycle 8.
2. Same setup, word 0x08 → mem[10..14] = 1,0,0,0,0; total = 1.
3. CW = 4, pattern 0000, len 20, all words 0x00 → bin5 = 15 (saturated); other bins 0; total = 100.
4. src_base 0xFE, len 4 → mem_re addresses FE, FF, 00, 01 on consecutive cycles; histogram matches a software model.
5. len 0 → no mem_re; five writes of 0 to dst..dst+4; done in cycle 6.
6. Two cases:
   - start pulsed again during SCAN → ignored; the job completes unchanged.
   - Reset_n dropped in cycle 3 → busy, mem_re and mem_we are 0 immediately; no writes follow; a new start afterwards yields a correct histogram.

Source files
------------

// File: rtl/pattern_hist_pkg.sv
// Shared types, default sizes and saturating arithmetic for the pattern histogram engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_hist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } hist_state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_PW = 4;
    localparam int DEF_AW = 8;
    localparam int DEF_CW = 8;

    // a + b clamped to lim; callers size lim to the all-ones value of their register
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/pattern_window_match.sv
// Counts the PW-bit sliding windows of a word that equal the pattern.
// Latency: purely combinational.
// Backpressure: none.
module pattern_window_match #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic [DW-1:0]                word,
    input  logic [PW-1:0]                pattern,
    output logic [$clog2(DW-PW+2)-1:0]   count
);

    localparam int CNW = $clog2(DW-PW+2);

    // compare every window position and tally the hits
    always_comb begin
        count = '0;
        for (int j = 0; j <= DW-PW; j++) begin
            if (word[j +: PW] == pattern) begin
                count = count + CNW'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_hist_engine.sv
// Scans a memory block, histograms per-word pattern-match counts, writes bins back.
// Latency: len reads + 1 drain + NB writes + 1 done cycle after start.
// Backpressure: none; memory must accept one access per cycle, start ignored while busy.
module pattern_hist_engine
    import pattern_hist_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [PW-1:0] pattern,
    input  logic [AW-1:0] src_base,
    input  logic [AW:0]   src_len,
    input  logic [AW-1:0] dst_base,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW+3:0] total
);

    localparam int NB = DW - PW + 1;
    localparam int MW = $clog2(NB + 1);
    localparam logic [31:0] BIN_MAX = 32'((64'd1 << CW) - 64'd1);
    localparam logic [31:0] TOT_MAX = 32'((64'd1 << (AW + 4)) - 64'd1);

    hist_state_t   state_q, state_d;
    logic [PW-1:0] pat_q;
    logic [AW-1:0] src_q, dst_q;
    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;          // word index in SCAN, bin index (k-1) in WRITE
    logic          rd_vld_q;       // mem_rdata carries a word this cycle
    logic [CW-1:0] bin_q [1:NB];
    logic [MW-1:0] match_cnt;
    logic [CW-1:0] hit_bin, hit_inc, wr_bin;
    logic [AW+3:0] total_nx;
    logic          accept, scan_last, write_last;

    assign accept     = (state_q == IDLE) && start;
    assign scan_last  = (idx_q == len_q - (AW+1)'(1));
    assign write_last = (idx_q == (AW+1)'(NB - 1));

    pattern_window_match #(
        .DW (DW),
        .PW (PW)
    ) u_match (
        .word    (mem_rdata),
        .pattern (pat_q),
        .count   (match_cnt)
    );

    // state register
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: an empty job skips straight to writing zero bins
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (src_len == '0) ? WRITE : SCAN;
            SCAN:    if (scan_last) state_d = DRAIN;
            DRAIN:   state_d = WRITE;
            WRITE:   if (write_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // memory port and status outputs decode directly from state so reset clears them at once
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            SCAN: begin
                mem_re   = 1'b1;
                mem_addr = src_q + idx_q[AW-1:0];
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = dst_q + idx_q[AW-1:0];
                mem_wdata = DW'(wr_bin);
            end
            default: ;
        endcase
    end

    assign busy = (state_q == SCAN) || (state_q == DRAIN) || (state_q == WRITE);
    assign done = (state_q == FIN);

    // bin selection for write-back and for the increment, plus saturating sums
    always_comb begin
        wr_bin  = '0;
        hit_bin = '0;
        for (int k = 1; k <= NB; k++) begin
            if (idx_q == (AW+1)'(k - 1)) wr_bin = bin_q[k];
            if (match_cnt == MW'(k))     hit_bin = bin_q[k];
        end
        hit_inc  = CW'(sat_add(32'(hit_bin), 32'd1, BIN_MAX));
        total_nx = (AW+4)'(sat_add(32'(total), 32'(match_cnt), TOT_MAX));
    end

    // job parameters, phase index and read-valid pipeline flag
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pat_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= mem_re;
            if (accept) begin
                pat_q <= pattern;
                src_q <= src_base;
                dst_q <= dst_base;
                len_q <= src_len;
                idx_q <= '0;
            end else if (state_d != state_q) begin
                idx_q <= '0;
            end else if (state_q == SCAN || state_q == WRITE) begin
                idx_q <= idx_q + (AW+1)'(1);
            end
        end
    end

    // histogram bins and match total; words with no match leave the bins alone
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            total <= '0;
            for (int k = 1; k <= NB; k++) bin_q[k] <= '0;
        end else if (accept) begin
            total <= '0;
            for (int k = 1; k <= NB; k++) bin_q[k] <= '0;
        end else if (rd_vld_q) begin
            total <= total_nx;
            for (int k = 1; k <= NB; k++) begin
                if (match_cnt == MW'(k)) bin_q[k] <= hit_inc;
            end
        end
    end

endmodule
